// File: rtl/storage_pkg.sv
// Shared definitions for the matrix storage RAM.
// Writers and handlers both import this package, so they agree on the slot
// layout, the header encoding and the writer state type.
//   Slot layout (word offsets from slot base):
//     HDR_OFFSET  : header {valid[31], cols[15:8], rows[7:0]}
//     NAME_OFFSET : two name words, name[0] in the low byte of the first
//     DATA_OFFSET : row-major elements
package storage_pkg;

  localparam int HDR_OFFSET    = 0;
  localparam int NAME_OFFSET   = 1;
  localparam int DATA_OFFSET   = 3;
  localparam int HDR_VALID_BIT = 31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REJECT,
    S_INVAL,
    S_NAME0,
    S_NAME1,
    S_DATA,
    S_COMMIT,
    S_DONE
  } writer_state_t;

  // Header word; the valid bit is the slot's "occupied" marker.
  function automatic logic [31:0] make_header(input logic [7:0] rows,
                                              input logic [7:0] cols,
                                              input logic       valid);
    logic [31:0] h;
    h                = '0;
    h[7:0]           = rows;
    h[15:8]          = cols;
    h[HDR_VALID_BIT] = valid;
    return h;
  endfunction

endpackage

// File: rtl/matrix_storage_writer.sv
// matrix_storage_writer: accepts one matrix (id, dimensions, 8-byte name,
// row-major element stream) and writes it into its slot of the shared
// matrix storage RAM.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   write_request / write_ready    start handshake (ready only in IDLE)
//   matrix_id, actual_rows/cols    target slot and dimensions
//   matrix_name[0:7]               8-byte name
//   data_in / data_valid           element stream
//   writer_ready                   high while elements are accepted
//   write_done / error             one-cycle completion / rejection pulses
//   abort                          cancel an in-progress write
//   busy                           not idle
//   mem_wr_en/addr/data            RAM write port
// Write order: header(valid=0), name0, name1, elements, header(valid=1).
// A slot therefore only reads as occupied once it is completely written.
module matrix_storage_writer
  import storage_pkg::*;
#(
  parameter int BLOCK_SIZE = 1152,
  parameter int NUM_SLOTS  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_request,
  output logic                  write_ready,
  input  logic [2:0]            matrix_id,
  input  logic [7:0]            actual_rows,
  input  logic [7:0]            actual_cols,
  input  logic [7:0]            matrix_name [0:7],
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  writer_ready,
  output logic                  write_done,
  output logic                  error,
  input  logic                  abort,
  output logic                  busy,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data
);

  writer_state_t         r_state;
  writer_state_t         w_state_next;
  logic                  r_write_ready, r_writer_ready, r_write_done, r_error, r_busy;
  logic                  r_mem_wr_en;
  logic [ADDR_WIDTH-1:0] r_mem_wr_addr;
  logic [DATA_WIDTH-1:0] r_mem_wr_data;
  logic [15:0]           r_cnt;
  logic [15:0]           r_total;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [7:0]            r_rows, r_cols;
  logic [63:0]           r_name;

  logic [63:0]           w_name_packed;
  logic [15:0]           w_prod;
  logic                  w_bad;
  logic                  w_latch, w_elem, w_done, w_error, w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;

  for (genvar gi = 0; gi < 8; gi++) begin : g_name
    assign w_name_packed[gi*8 +: 8] = matrix_name[gi];
  end

  assign w_prod = 16'(actual_rows) * 16'(actual_cols);
  assign w_bad  = (int'(matrix_id) >= NUM_SLOTS) || (actual_rows == 8'd0) ||
                  (actual_cols == 8'd0) || (int'(w_prod) > BLOCK_SIZE - DATA_OFFSET);

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_elem       = 1'b0;
    w_done       = 1'b0;
    w_error      = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_addr    = r_mem_wr_addr;
    w_wr_data    = r_mem_wr_data;
    unique case (r_state)
      S_IDLE: begin
        if (write_request) begin
          w_latch      = 1'b1;
          w_state_next = w_bad ? S_REJECT : S_INVAL;
        end
      end
      S_REJECT: begin
        w_error      = 1'b1;
        w_state_next = S_IDLE;
      end
      S_INVAL: begin
        w_wr_en      = 1'b1;
        w_wr_addr    = r_base + ADDR_WIDTH'(HDR_OFFSET);
        w_wr_data    = DATA_WIDTH'(make_header(r_rows, r_cols, 1'b0));
        w_state_next = S_NAME0;
      end
      S_NAME0: begin
        w_wr_en      = 1'b1;
        w_wr_addr    = r_base + ADDR_WIDTH'(NAME_OFFSET);
        w_wr_data    = DATA_WIDTH'(r_name[31:0]);
        w_state_next = S_NAME1;
      end
      S_NAME1: begin
        w_wr_en      = 1'b1;
        w_wr_addr    = r_base + ADDR_WIDTH'(NAME_OFFSET + 1);
        w_wr_data    = DATA_WIDTH'(r_name[63:32]);
        w_state_next = S_DATA;
      end
      S_DATA: begin
        if (data_valid) begin
          w_elem    = 1'b1;
          w_wr_en   = 1'b1;
          w_wr_addr = r_base + ADDR_WIDTH'(DATA_OFFSET) + ADDR_WIDTH'(r_cnt);
          w_wr_data = data_in;
          if (r_cnt == r_total - 16'd1) w_state_next = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_wr_en      = 1'b1;
        w_wr_addr    = r_base + ADDR_WIDTH'(HDR_OFFSET);
        w_wr_data    = DATA_WIDTH'(make_header(r_rows, r_cols, 1'b1));
        w_state_next = S_DONE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // Abort cancels whatever the current state would have done, including a
    // final element arriving in the same cycle. DONE has already committed.
    if (abort && (r_state != S_IDLE) && (r_state != S_DONE)) begin
      w_state_next = S_IDLE;
      w_elem       = 1'b0;
      w_done       = 1'b0;
      w_error      = 1'b0;
      w_wr_en      = 1'b0;
      w_wr_addr    = r_mem_wr_addr;
      w_wr_data    = r_mem_wr_data;
    end
  end

  // Status flags are registered from the next state so they always match the
  // state the FSM is in during the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_write_ready  <= 1'b1;
      r_busy         <= 1'b0;
      r_writer_ready <= 1'b0;
      r_write_done   <= 1'b0;
      r_error        <= 1'b0;
      r_mem_wr_en    <= 1'b0;
      r_mem_wr_addr  <= '0;
      r_mem_wr_data  <= '0;
      r_cnt          <= '0;
    end else begin
      r_state        <= w_state_next;
      r_write_ready  <= (w_state_next == S_IDLE);
      r_busy         <= (w_state_next != S_IDLE);
      r_writer_ready <= (w_state_next == S_DATA);
      r_write_done   <= w_done;
      r_error        <= w_error;
      r_mem_wr_en    <= w_wr_en;
      r_mem_wr_addr  <= w_wr_addr;
      r_mem_wr_data  <= w_wr_data;
      if (w_latch)     r_cnt <= '0;
      else if (w_elem) r_cnt <= r_cnt + 16'd1;
    end
  end

  // Request fields are captured once; the slot base multiply happens here so
  // the address path in later states is a plain add.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_base  <= ADDR_WIDTH'(int'(matrix_id) * BLOCK_SIZE);
      r_rows  <= actual_rows;
      r_cols  <= actual_cols;
      r_total <= w_prod;
      r_name  <= w_name_packed;
    end
  end

  assign write_ready  = r_write_ready;
  assign busy         = r_busy;
  assign writer_ready = r_writer_ready;
  assign write_done   = r_write_done;
  assign error        = r_error;
  assign mem_wr_en    = r_mem_wr_en;
  assign mem_wr_addr  = r_mem_wr_addr;
  assign mem_wr_data  = r_mem_wr_data;

endmodule

// File: tb/tb_matrix_storage_writer.sv
// Self-checking bench for matrix_storage_writer. Expected RAM write
// sequences and pulse timing are built from the slot layout rules; observed
// writes are collected by a monitor and compared in order.
module tb_matrix_storage_writer;

  localparam int BS = 1152;
  localparam int AW = 14;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          req = 1'b0, req6 = 1'b0, abort = 1'b0, data_valid = 1'b0;
  logic [2:0]    matrix_id = '0;
  logic [7:0]    actual_rows = '0, actual_cols = '0;
  logic [7:0]    matrix_name [0:7];
  logic [DW-1:0] data_in = '0;

  logic          write_ready, writer_ready, write_done, error, busy, mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          write_ready_6, writer_ready_6, write_done_6, error_6, busy_6, mem_wr_en_6;
  logic [AW-1:0] mem_wr_addr_6;
  logic [DW-1:0] mem_wr_data_6;

  int checks = 0;
  int failures = 0;
  logic [AW+DW-1:0] got_q[$];
  logic [AW+DW-1:0] got6_q[$];

  matrix_storage_writer #(.BLOCK_SIZE(BS), .NUM_SLOTS(8), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .write_request(req), .write_ready(write_ready),
    .matrix_id(matrix_id), .actual_rows(actual_rows), .actual_cols(actual_cols),
    .matrix_name(matrix_name), .data_in(data_in), .data_valid(data_valid),
    .writer_ready(writer_ready), .write_done(write_done), .error(error), .abort(abort),
    .busy(busy), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  matrix_storage_writer #(.BLOCK_SIZE(BS), .NUM_SLOTS(6), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut6 (
    .clk(clk), .rst(rst), .write_request(req6), .write_ready(write_ready_6),
    .matrix_id(matrix_id), .actual_rows(actual_rows), .actual_cols(actual_cols),
    .matrix_name(matrix_name), .data_in(data_in), .data_valid(data_valid),
    .writer_ready(writer_ready_6), .write_done(write_done_6), .error(error_6), .abort(abort),
    .busy(busy_6), .mem_wr_en(mem_wr_en_6), .mem_wr_addr(mem_wr_addr_6), .mem_wr_data(mem_wr_data_6)
  );

  always @(negedge clk) begin
    if (mem_wr_en === 1'b1)   got_q.push_back({mem_wr_addr, mem_wr_data});
    if (mem_wr_en_6 === 1'b1) got6_q.push_back({mem_wr_addr_6, mem_wr_data_6});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] hdr(input int r, input int c, input bit v);
    return {v, 15'd0, 8'(c), 8'(r)};
  endfunction

  task automatic set_req(input int id, input int rows, input int cols, input logic [63:0] nm);
    matrix_id   = 3'(id);
    actual_rows = 8'(rows);
    actual_cols = 8'(cols);
    for (int i = 0; i < 8; i++) matrix_name[i] = nm[i*8 +: 8];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (write_ready !== 1'b1)  begin failures++; $display("FAIL reset_write_ready: got %b expected 1", write_ready); end
    checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (writer_ready !== 1'b0) begin failures++; $display("FAIL reset_writer_ready: got %b expected 0", writer_ready); end
    checks++; if (write_done !== 1'b0)   begin failures++; $display("FAIL reset_write_done: got %b expected 0", write_done); end
    checks++; if (error !== 1'b0)        begin failures++; $display("FAIL reset_error: got %b expected 0", error); end
    checks++; if (mem_wr_en !== 1'b0)    begin failures++; $display("FAIL reset_mem_wr_en: got %b expected 0", mem_wr_en); end
    checks++; if (mem_wr_addr !== '0)    begin failures++; $display("FAIL reset_mem_wr_addr: got %0h expected 0", mem_wr_addr); end
    checks++; if (mem_wr_data !== '0)    begin failures++; $display("FAIL reset_mem_wr_data: got %0h expected 0", mem_wr_data); end
    rst = 1'b0;
    tick();
    $display("reset: checked idle outputs");
  endtask

  // mode: 0 full rate, 1 alternate valid, 2 random valid.
  // abort_at >= 0: assert abort (together with an element) once that many elements were accepted.
  task automatic run_write(input string tag, input int id, input int rows, input int cols,
                           input logic [63:0] nm, input int mode, input bit seq_elems,
                           input int abort_at);
    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    elems[$];
    int n, base, stop, k, acc, k_last, k_done, bound, exp_done;
    bit aborted;
    n = rows * cols;
    base = id * BS;
    for (int i = 0; i < n; i++) elems.push_back(seq_elems ? DW'(i + 1) : DW'($urandom));
    exp_q.push_back({AW'(base), hdr(rows, cols, 1'b0)});
    exp_q.push_back({AW'(base + 1), nm[31:0]});
    exp_q.push_back({AW'(base + 2), nm[63:32]});
    stop = (abort_at >= 0) ? abort_at : n;
    for (int i = 0; i < stop; i++) exp_q.push_back({AW'(base + 3 + i), elems[i]});
    if (abort_at < 0) exp_q.push_back({AW'(base), hdr(rows, cols, 1'b1)});

    got_q.delete();
    set_req(id, rows, cols, nm);
    req = 1'b1;
    tick();
    req = 1'b0;
    k = 0; acc = 0; k_last = -1; k_done = -1; aborted = 1'b0;
    bound = n * 4 + 40;
    while (k < bound) begin
      if (write_done === 1'b1) begin
        k_done = k;
        break;
      end
      data_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((k % 2) == 0) : 1'($urandom_range(0, 1));
      data_in = (writer_ready === 1'b1 && acc < n) ? elems[acc] : (32'hBAD0_0000 | DW'(k));
      if (writer_ready === 1'b1 && abort_at >= 0 && acc == abort_at) begin
        abort = 1'b1;
        data_valid = 1'b1;
      end else if (writer_ready === 1'b1 && data_valid && acc < n) begin
        acc++;
        if (acc == n) k_last = k;
      end
      tick();
      k++;
      if (abort) begin
        abort = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    data_valid = 1'b0;

    if (abort_at < 0) begin
      exp_done = (mode == 0) ? n + 5 : k_last + 3;
      checks++;
      if (k_done != exp_done) begin
        failures++;
        $display("FAIL %s done_cycle: got %0d expected %0d", tag, k_done, exp_done);
      end
      tick();
      checks++;
      if (write_done !== 1'b0 || write_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s done_pulse: got done=%b ready=%b expected done=0 ready=1", tag, write_done, write_ready);
      end
    end else begin
      checks++;
      if (!aborted || write_ready !== 1'b1 || writer_ready !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL %s abort_idle: got aborted=%b ready=%b wready=%b busy=%b expected 1/1/0/0",
                 tag, aborted, write_ready, writer_ready, busy);
      end
      for (int i = 0; i < 6; i++) begin
        tick();
        checks++;
        if (write_done !== 1'b0 || error !== 1'b0) begin
          failures++;
          $display("FAIL %s abort_quiet: got done=%b error=%b expected 0/0", tag, write_done, error);
        end
      end
    end

    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s write_count: got %0d expected %0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s write[%0d]: got addr=%0d data=%08h expected addr=%0d data=%08h", tag, i,
                 got_q[i][AW+DW-1:DW], got_q[i][DW-1:0], exp_q[i][AW+DW-1:DW], exp_q[i][DW-1:0]);
      end
    end
    $display("%s: id=%0d %0dx%0d mode=%0d abort_at=%0d writes=%0d done_cycle=%0d",
             tag, id, rows, cols, mode, abort_at, got_q.size(), k_done);
  endtask

  task automatic test_reject(input string tag, input bit use6, input int id, input int rows, input int cols);
    logic e, rdy, bsy, wrdy, dn;
    got_q.delete();
    got6_q.delete();
    set_req(id, rows, cols, 64'h0);
    if (use6) req6 = 1'b1; else req = 1'b1;
    data_valid = 1'b0;
    tick();
    req = 1'b0;
    req6 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      e    = use6 ? error_6 : error;
      rdy  = use6 ? write_ready_6 : write_ready;
      bsy  = use6 ? busy_6 : busy;
      wrdy = use6 ? writer_ready_6 : writer_ready;
      dn   = use6 ? write_done_6 : write_done;
      checks++;
      if (e !== (k == 1)) begin
        failures++;
        $display("FAIL %s error_k%0d: got %b expected %b", tag, k, e, (k == 1));
      end
      if (k >= 1) begin
        checks++;
        if (rdy !== 1'b1 || bsy !== 1'b0 || wrdy !== 1'b0 || dn !== 1'b0) begin
          failures++;
          $display("FAIL %s idle_k%0d: got ready=%b busy=%b wready=%b done=%b expected 1/0/0/0",
                   tag, k, rdy, bsy, wrdy, dn);
        end
      end
      tick();
    end
    checks++;
    if (got_q.size() + got6_q.size() != 0) begin
      failures++;
      $display("FAIL %s ram_writes: got %0d expected 0", tag, got_q.size() + got6_q.size());
    end
    $display("%s: id=%0d %0dx%0d rejected", tag, id, rows, cols);
  endtask

  task automatic test_reset_mid();
    int acc, n0, guard;
    got_q.delete();
    set_req(1, 2, 2, 64'h1122334455667788);
    req = 1'b1;
    tick();
    req = 1'b0;
    data_valid = 1'b1;
    acc = 0;
    guard = 0;
    while (acc < 2 && guard < 20) begin
      data_in = DW'($urandom);
      if (writer_ready === 1'b1) acc++;
      tick();
      guard++;
    end
    rst = 1'b1;
    tick();
    checks++;
    if (write_ready !== 1'b1 || writer_ready !== 1'b0 || mem_wr_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_idle: got ready=%b wready=%b wr_en=%b busy=%b expected 1/0/0/0",
               write_ready, writer_ready, mem_wr_en, busy);
    end
    rst = 1'b0;
    n0 = got_q.size();
    for (int i = 0; i < 4; i++) tick();
    data_valid = 1'b0;
    checks++;
    if (got_q.size() != n0) begin
      failures++;
      $display("FAIL reset_mid_writes: got %0d extra writes expected 0", got_q.size() - n0);
    end
    $display("reset_mid: reset during DATA after %0d elements", acc);
    run_write("after_reset", 1, 2, 2, 64'h1122334455667788, 0, 1'b0, -1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) matrix_name[i] = 8'h00;
    test_reset();
    // "MAT_A" with name[0] = 'M'
    run_write("basic", 2, 2, 3, 64'h00000041_5F54414D, 0, 1'b1, -1);
    run_write("toggled", 2, 2, 3, 64'h00000041_5F54414D, 1, 1'b1, -1);
    run_write("random_gaps", 2, 2, 3, 64'h00000041_5F54414D, 2, 1'b1, -1);
    test_reject("rows_zero", 1'b0, 3, 0, 5);
    test_reject("cols_zero", 1'b0, 3, 5, 0);
    test_reject("too_big", 1'b0, 0, 40, 30);
    test_reject("just_too_big", 1'b0, 4, 5, 230);
    test_reject("id7_of6", 1'b1, 7, 2, 2);
    test_reject("id6_of6", 1'b1, 6, 2, 2);
    run_write("large", 7, 33, 33, {$urandom, $urandom}, 0, 1'b0, -1);
    run_write("abort_mid", 2, 2, 3, 64'h00000041_5F54414D, 0, 1'b1, 3);
    run_write("after_abort", 2, 2, 3, 64'h00000041_5F54414D, 0, 1'b1, -1);
    run_write("abort_last", 5, 2, 3, {$urandom, $urandom}, 2, 1'b0, 5);
    test_reset_mid();
    for (int t = 0; t < 5; t++) begin
      run_write("random", int'($urandom_range(0, 7)), int'($urandom_range(1, 5)),
                int'($urandom_range(1, 5)), {$urandom, $urandom}, int'($urandom_range(0, 2)), 1'b0, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_storage_writer.md
Name: matrix_storage_writer

Overview:
- Consumer of the matrix write interface driven by the matrix input and random-generation handlers: accepts one matrix (id, dimensions, 8-byte name, row-major element stream) and writes it into the shared matrix storage RAM.
- Storage holds NUM_SLOTS slots of BLOCK_SIZE words. Each slot is laid out as: header word, two name words, then the elements.
- The slot header doubles as the "occupied" marker that handlers read back when searching for empty slots.

Parameters:
- BLOCK_SIZE, 1152, words per slot (3 metadata words + up to 1149 elements)
- NUM_SLOTS, 8, number of matrix slots; matrix_id range is 0..NUM_SLOTS-1
- DATA_WIDTH, 32, element and RAM word width
- ADDR_WIDTH, 14, storage RAM address width; must satisfy NUM_SLOTS*BLOCK_SIZE <= 2^ADDR_WIDTH

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- write_request  in  1  start request; sampled only while write_ready=1
- write_ready  out  1  high in IDLE
- matrix_id  in  3  target slot
- actual_rows  in  8  row count
- actual_cols  in  8  column count
- matrix_name  in  8x8  unpacked byte array [0:7]
- data_in  in  DATA_WIDTH  element value
- data_valid  in  1  element strobe
- writer_ready  out  1  high while element words are being accepted
- write_done  out  1  one-cycle pulse: matrix committed
- error  out  1  one-cycle pulse: request rejected
- abort  in  1  cancel an in-progress write
- busy  out  1  high in any state other than IDLE
- mem_wr_en  out  1  RAM write enable
- mem_wr_addr  out  ADDR_WIDTH  RAM write address
- mem_wr_data  out  DATA_WIDTH  RAM write data

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-high.
- Reset values: write_ready=1, busy=0, writer_ready=0, write_done=0, error=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0; state=IDLE; element counter=0.
- All outputs are registered.
- Header word format: [7:0]=rows, [15:8]=cols, [31]=valid, all other bits 0.
- Name words:
  - base+1 = {name[3],name[2],name[1],name[0]}, with name[0] in bits [7:0]
  - base+2 = {name[7],name[6],name[5],name[4]}
- Elements occupy base+3+k for k = 0..rows*cols-1.
- base = matrix_id*BLOCK_SIZE, computed once and registered at request acceptance.
- IDLE: when write_request=1, latch id/rows/cols/name. Then:
  - Reject (→ REJECT) if id >= NUM_SLOTS, rows=0, cols=0, or rows*cols > BLOCK_SIZE-3. The product is 16 bits wide.
  - Otherwise → INVAL.
- REJECT: error=1 for one cycle, no RAM write, → IDLE.
- INVAL: write header with valid=0 at base. This ensures a partially written slot never reads as occupied. → NAME0.
- NAME0: write base+1. → NAME1.
- NAME1: write base+2. → DATA.
- DATA:
  - writer_ready=1.
  - Each cycle with data_valid=1 writes data_in to base+3+cnt and increments cnt.
  - data_valid while writer_ready=0 is ignored; no buffering.
  - Exactly one RAM write per cycle.
  - When the last element (cnt = rows*cols-1) is accepted, writer_ready drops the next cycle. → COMMIT.
- COMMIT: write header with valid=1 at base. → DONE.
- DONE: write_done=1 for one cycle, mem_wr_en=0. → IDLE.
- Latency: request accepted at edge E0 → INVAL write visible in cycle E0+1. For N elements at full rate, write_done is high at cycle E0+N+5.
- abort=1 in any state other than IDLE/DONE: → IDLE next cycle with no further writes, no write_done and no error. The header keeps valid=0 if INVAL has already executed.
- abort and the final element in the same cycle: abort wins; the element is not written.
- write_request outside IDLE is ignored.
- rst mid-operation returns to IDLE immediately; no further RAM writes.

Decomposition:
- Shared package storage_pkg holds:
  - slot layout constants: HDR_OFFSET=0, NAME_OFFSET=1, DATA_OFFSET=3
  - HDR_VALID_BIT=31
  - the writer state enum
  - helper function make_header(rows, cols, valid)
- Handlers use the same package to decode headers.
- No sub-module is needed. The base-address multiply by a constant is a single registered expression.

Test Plan:
- id=2, rows=2, cols=3, name "MAT_A\0\0\0", elements 1..6 streamed at full rate:
  - writes at 2304 (hdr 0x00000302), 2305 = 0x5F54414D, 2306 = 0x00000041, 2307..2312 = 1..6, then 2304 = 0x80000302
  - write_done exactly 1 cycle at E0+11
- Same request with data_valid toggled 1/0: no element lost or duplicated; final address 2312; done only after the 6th accepted element.
- Each of the following gives error=1 for one cycle, zero RAM writes, write_ready=1 the next cycle:
  - rows=0
  - id=7 with NUM_SLOTS=6
  - rows=40, cols=30 (1200 > 1149)
- rows=cols=33 (1089 elements) into id=7: last element at 8064+3+1088=9155 < 9216; commit header 0x80002121.
- abort after 3 of 6 elements: no further writes; header at base remains 0x00000302 (valid=0); no write_done; next request accepted normally.
- rst asserted during DATA: the next cycle shows write_ready=1, writer_ready=0, mem_wr_en=0; a subsequent full write completes correctly.
